// File: rtl/cpu_pkg.sv
// Shared encodings for the Simple RISC multicycle control unit:
// opcodes, ALU selects, PC source selects and the control state enum.
package cpu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h5;
   localparam logic [3:0] OP_ST   = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;

   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   // Address arithmetic (ADDI/LD/ST) uses ADD; BEQ compares by subtraction.
   function automatic logic [2:0] exec_alu_op(input logic [3:0] opc);
      case (opc)
         OP_SUB, OP_BEQ: return ALU_SUB;
         OP_AND:         return ALU_AND;
         OP_OR:          return ALU_OR;
         default:        return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT, outputs decoded from state + IR.
// Latency (no wait states): JMP 2, BEQ 3, R-type/ADDI/ST 4, LD 5 cycles.
// Backpressure: FETCH and MEM hold their request until mem_ready. CPU_CTRL_PERF_EN adds instr_retired.
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int OPC_W   = 4,
   parameter int ALUOP_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        instr,
   input  logic               alu_zero,
   input  logic               mem_ready,
   output logic               pc_en,
   output logic [1:0]         pc_sel,
   output logic               ir_load,
   output logic               mem_re,
   output logic               mem_we,
   output logic               addr_sel,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               alu_src_imm,
   output logic               reg_we,
   output logic               mem_to_reg,
   output logic               halt
`ifdef CPU_CTRL_PERF_EN
   ,
   output logic [15:0]        instr_retired
`endif
);

   state_t           r_state;
   logic [OPC_W-1:0] w_opc;
   logic             w_unused_instr;
   logic             w_is_rtype;
   logic             w_is_addi;
   logic             w_is_ld;
   logic             w_is_st;
   logic             w_is_beq;
   logic             w_is_jmp;
   logic             w_is_halt;
   logic             w_is_nop;
   logic             w_retire;

   assign w_opc          = instr[15 -: OPC_W];
   assign w_unused_instr = ^instr[15-OPC_W:0];

   assign w_is_rtype = (w_opc == OP_ADD) || (w_opc == OP_SUB) ||
                       (w_opc == OP_AND) || (w_opc == OP_OR);
   assign w_is_addi  = (w_opc == OP_ADDI);
   assign w_is_ld    = (w_opc == OP_LD);
   assign w_is_st    = (w_opc == OP_ST);
   assign w_is_beq   = (w_opc == OP_BEQ);
   assign w_is_jmp   = (w_opc == OP_JMP);
   assign w_is_halt  = (w_opc == OP_HALT);
   assign w_is_nop   = !(w_is_rtype || w_is_addi || w_is_ld || w_is_st ||
                         w_is_beq || w_is_jmp || w_is_halt);

   // Outputs are forced idle while reset is high so an in-flight bus access is dropped at once.
   always_comb begin
      pc_en       = 1'b0;
      pc_sel      = PC_INC;
      ir_load     = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      alu_op      = '0;
      alu_src_imm = 1'b0;
      reg_we      = 1'b0;
      mem_to_reg  = 1'b0;
      halt        = 1'b0;
      w_retire    = 1'b0;
      if (!reset) begin
         case (r_state)
            FETCH: begin
               mem_re  = 1'b1;
               ir_load = mem_ready;
            end
            DECODE: begin
               if (w_is_jmp) begin
                  pc_en    = 1'b1;
                  pc_sel   = PC_JMP;
                  w_retire = 1'b1;
               end else if (w_is_nop) begin
                  pc_en    = 1'b1;
                  w_retire = 1'b1;
               end
            end
            EXEC: begin
               alu_op      = ALUOP_W'(exec_alu_op(w_opc));
               alu_src_imm = w_is_addi || w_is_ld || w_is_st;
               if (w_is_beq) begin
                  pc_en    = 1'b1;
                  pc_sel   = alu_zero ? PC_BR : PC_INC;
                  w_retire = 1'b1;
               end
            end
            MEM: begin
               addr_sel    = 1'b1;
               alu_op      = ALUOP_W'(ALU_ADD);
               alu_src_imm = 1'b1;
               mem_re      = w_is_ld;
               mem_we      = w_is_st;
               if (w_is_st && mem_ready) begin
                  pc_en    = 1'b1;
                  w_retire = 1'b1;
               end
            end
            WB: begin
               reg_we     = 1'b1;
               pc_en      = 1'b1;
               mem_to_reg = w_is_ld;
               w_retire   = 1'b1;
            end
            HALT: begin
               halt = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef CPU_CTRL_PERF_EN
   logic [15:0] r_retired;
   assign instr_retired = r_retired;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FETCH;
`ifdef CPU_CTRL_PERF_EN
         r_retired <= '0;
`endif
      end else begin
         case (r_state)
            FETCH:   if (mem_ready) r_state <= DECODE;
            DECODE: begin
               if (w_is_halt)                 r_state <= HALT;
               else if (w_is_jmp || w_is_nop) r_state <= FETCH;
               else                           r_state <= EXEC;
            end
            EXEC: begin
               if (w_is_ld || w_is_st) r_state <= MEM;
               else if (w_is_beq)      r_state <= FETCH;
               else                    r_state <= WB;
            end
            MEM:     if (mem_ready) r_state <= w_is_ld ? WB : FETCH;
            WB:      r_state <= FETCH;
            HALT:    r_state <= HALT;
            default: r_state <= FETCH;
         endcase
`ifdef CPU_CTRL_PERF_EN
         if (w_retire) r_retired <= r_retired + 16'd1;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Table-driven bench for cpu_ctrl_fsm: one row per clock cycle, expected outputs queued at drive time.
module tb_cpu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        alu_zero;
   logic        mem_ready;
   logic        pc_en;
   logic [1:0]  pc_sel;
   logic        ir_load;
   logic        mem_re;
   logic        mem_we;
   logic        addr_sel;
   logic [2:0]  alu_op;
   logic        alu_src_imm;
   logic        reg_we;
   logic        mem_to_reg;
   logic        halt;
`ifdef CPU_CTRL_PERF_EN
   logic [15:0] instr_retired;
`endif

   cpu_ctrl_fsm #(.OPC_W(4), .ALUOP_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .alu_zero    (alu_zero),
      .mem_ready   (mem_ready),
      .pc_en       (pc_en),
      .pc_sel      (pc_sel),
      .ir_load     (ir_load),
      .mem_re      (mem_re),
      .mem_we      (mem_we),
      .addr_sel    (addr_sel),
      .alu_op      (alu_op),
      .alu_src_imm (alu_src_imm),
      .reg_we      (reg_we),
      .mem_to_reg  (mem_to_reg),
      .halt        (halt)
`ifdef CPU_CTRL_PERF_EN
      ,
      .instr_retired (instr_retired)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic [15:0] ins;
      logic        zero;
      logic        rdy;
      logic [13:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [13:0] sb_q[$];
   string       sb_nm[$];
   int          errors = 0;
   int          checks = 0;

   // Field order: pc_en, pc_sel, ir_load, mem_re, mem_we, addr_sel, alu_op, alu_src_imm, reg_we, mem_to_reg, halt
   function automatic logic [13:0] ex(input logic pe, input logic [1:0] ps, input logic irl,
                                      input logic re, input logic we, input logic as,
                                      input logic [2:0] op, input logic imm, input logic rwe,
                                      input logic m2r, input logic h);
      return {pe, ps, irl, re, we, as, op, imm, rwe, m2r, h};
   endfunction

   task automatic row(input string nm, input logic rst, input logic [15:0] ins,
                      input logic z, input logic rdy, input logic [13:0] e);
      vec_t v;
      v.name = nm; v.rst = rst; v.ins = ins; v.zero = z; v.rdy = rdy; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic push_exp(input string nm, input logic [13:0] e);
      sb_q.push_back(e);
      sb_nm.push_back(nm);
   endtask

   task automatic pop_cmp();
      logic [13:0] act;
      logic [13:0] e;
      string       nm;
      act = {pc_en, pc_sel, ir_load, mem_re, mem_we, addr_sel, alu_op,
             alu_src_imm, reg_we, mem_to_reg, halt};
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %h required an expected entry", act);
      end else begin
         e  = sb_q.pop_front();
         nm = sb_nm.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, e);
         end
      end
   endtask

   // Called at posedge+1; inputs held for the whole cycle, outputs sampled at the negedge.
   task automatic step(input string nm, input logic rst, input logic [15:0] ins,
                       input logic z, input logic rdy, input logic [13:0] e);
      reset = rst; instr = ins; alu_zero = z; mem_ready = rdy;
      push_exp(nm, e);
      @(negedge clk);
      pop_cmp();
      @(posedge clk);
      #1;
   endtask

`ifdef CPU_CTRL_PERF_EN
   task automatic cnt_chk(input string nm, input logic [15:0] e);
      checks++;
      if (instr_retired !== e) begin
         errors++;
         $display("FAIL %s: instr_retired got %0d required %0d", nm, instr_retired, e);
      end
   endtask
`endif

   initial begin
      logic [13:0] idle, fet, fwait, wb, mem_imm;
      idle    = '0;
      fet     = ex(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      fwait   = ex(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      wb      = ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      mem_imm = ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      row("rst_a",        1, 16'h0123, 0, 1, idle);
      row("rst_b",        1, 16'h0123, 0, 0, idle);
      row("add_fetch",    0, 16'h0123, 0, 1, fet);
      row("add_dec",      0, 16'h0123, 0, 1, idle);
      row("add_exec",     0, 16'h0123, 1, 1, idle);
      row("add_wb",       0, 16'h0123, 0, 1, wb);
      row("fetch_wait",   0, 16'h0123, 0, 0, fwait);
      row("sub_fetch",    0, 16'h1456, 0, 1, fet);
      row("sub_dec",      0, 16'h1456, 0, 0, idle);
      row("sub_exec",     0, 16'h1456, 0, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      row("sub_wb",       0, 16'h1456, 0, 0, wb);
      row("and_fetch",    0, 16'h2789, 0, 1, fet);
      row("and_dec",      0, 16'h2789, 0, 1, idle);
      row("and_exec",     0, 16'h2789, 0, 1, ex(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
      row("and_wb",       0, 16'h2789, 0, 1, wb);
      row("or_fetch",     0, 16'h3ABC, 0, 1, fet);
      row("or_dec",       0, 16'h3ABC, 0, 1, idle);
      row("or_exec",      0, 16'h3ABC, 0, 1, ex(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
      row("or_wb",        0, 16'h3ABC, 0, 1, wb);
      row("addi_fetch",   0, 16'h4105, 0, 1, fet);
      row("addi_dec",     0, 16'h4105, 0, 1, idle);
      row("addi_exec",    0, 16'h4105, 0, 1, mem_imm);
      row("addi_wb",      0, 16'h4105, 0, 1, wb);
      row("ld_fetch",     0, 16'h5207, 0, 1, fet);
      row("ld_dec",       0, 16'h5207, 0, 1, idle);
      row("ld_exec",      0, 16'h5207, 0, 1, mem_imm);
      row("ld_mem_w0",    0, 16'h5207, 0, 0, ex(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0));
      row("ld_mem_w1",    0, 16'h5207, 0, 0, ex(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0));
      row("ld_mem_w2",    0, 16'h5207, 0, 0, ex(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0));
      row("ld_mem_done",  0, 16'h5207, 0, 1, ex(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0));
      row("ld_wb",        0, 16'h5207, 0, 1, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      row("st_fetch",     0, 16'h6301, 0, 1, fet);
      row("st_dec",       0, 16'h6301, 0, 1, idle);
      row("st_exec",      0, 16'h6301, 0, 1, mem_imm);
      row("st_mem_w0",    0, 16'h6301, 0, 0, ex(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
      row("st_mem_done",  0, 16'h6301, 0, 1, ex(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
      row("beq1_fetch",   0, 16'h7004, 1, 1, fet);
      row("beq1_dec",     0, 16'h7004, 1, 1, idle);
      row("beq1_exec",    0, 16'h7004, 1, 1, ex(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      row("beq0_fetch",   0, 16'h7004, 0, 1, fet);
      row("beq0_dec",     0, 16'h7004, 0, 1, idle);
      row("beq0_exec",    0, 16'h7004, 0, 1, ex(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      row("jmp_fetch",    0, 16'h8123, 0, 1, fet);
      row("jmp_dec",      0, 16'h8123, 0, 1, ex(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      row("nop_fetch",    0, 16'hB000, 0, 1, fet);
      row("nop_dec",      0, 16'hB000, 0, 1, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      row("nop_refetch",  0, 16'hB000, 0, 0, fwait);

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].name, tbl[i].rst, tbl[i].ins, tbl[i].zero, tbl[i].rdy, tbl[i].exp);

      // Reset in the middle of a stalled store must drop mem_we in the same cycle.
      step("st2_fetch", 0, 16'h6034, 0, 1, fet);
      step("st2_dec",   0, 16'h6034, 0, 1, idle);
      step("st2_exec",  0, 16'h6034, 0, 1, mem_imm);
      mem_ready = 1'b0;
      push_exp("st2_mem_we", ex(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
      @(negedge clk);
      pop_cmp();
      #1 reset = 1'b1;
      push_exp("rst_drop_we", idle);
      #1 pop_cmp();
      @(posedge clk);
      push_exp("rst_hold", idle);
      @(negedge clk);
      pop_cmp();
      reset = 1'b0;
      @(posedge clk);
      #1;
      step("rst_fetch", 0, 16'h6034, 0, 0, fwait);

      // HALT is terminal and sticky; mem_ready toggling must not disturb it.
      step("halt_fetch", 0, 16'hF000, 0, 1, fet);
      step("halt_dec",   0, 16'hF000, 0, 1, idle);
      for (int i = 0; i < 20; i++)
         step("halt_hold", 0, 16'hF000, i[1], i[0], ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      step("halt_rst",   1, 16'hF000, 0, 1, idle);
`ifdef CPU_CTRL_PERF_EN
      cnt_chk("cnt_reset", 16'd0);
`endif
      step("post_halt_fetch", 0, 16'h0000, 0, 0, fwait);

      // ADD, ADDI, ST, JMP, HALT: four retirements, then frozen.
      step("p_add_fetch",  0, 16'h0123, 0, 1, fet);
      step("p_add_dec",    0, 16'h0123, 0, 1, idle);
      step("p_add_exec",   0, 16'h0123, 0, 1, idle);
      step("p_add_wb",     0, 16'h0123, 0, 1, wb);
`ifdef CPU_CTRL_PERF_EN
      cnt_chk("cnt_after_add", 16'd1);
`endif
      step("p_addi_fetch", 0, 16'h4001, 0, 1, fet);
      step("p_addi_dec",   0, 16'h4001, 0, 1, idle);
      step("p_addi_exec",  0, 16'h4001, 0, 1, mem_imm);
      step("p_addi_wb",    0, 16'h4001, 0, 1, wb);
      step("p_st_fetch",   0, 16'h6000, 0, 1, fet);
      step("p_st_dec",     0, 16'h6000, 0, 1, idle);
      step("p_st_exec",    0, 16'h6000, 0, 1, mem_imm);
      step("p_st_mem",     0, 16'h6000, 0, 1, ex(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
      step("p_jmp_fetch",  0, 16'h8010, 0, 1, fet);
      step("p_jmp_dec",    0, 16'h8010, 0, 1, ex(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef CPU_CTRL_PERF_EN
      cnt_chk("cnt_after_jmp", 16'd4);
`endif
      step("p_halt_fetch", 0, 16'hF000, 0, 1, fet);
      step("p_halt_dec",   0, 16'hF000, 0, 1, idle);
      for (int i = 0; i < 5; i++)
         step("p_halted", 0, 16'hF000, 0, i[0], ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef CPU_CTRL_PERF_EN
      cnt_chk("cnt_halted", 16'd4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
